// File: rtl/aac_row_sequencer_pkg.sv
// Shared types and widths for the AAC row sequencer and its result FIFO.
package aac_row_sequencer_pkg;

  localparam int unsigned AAC_DATA_W = 24;
  localparam int unsigned AAC_ROW_W  = 8;

  typedef enum logic {
    ROW_IDLE = 1'b0,
    ROW_OPEN = 1'b1
  } row_state_t;

  typedef struct packed {
    logic [AAC_ROW_W-1:0]  row;
    logic [AAC_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/aac_result_fifo.sv
// Small synchronous result FIFO; head entry is presented combinationally.
module aac_result_fifo
  import aac_row_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fifo_entry_t      push_entry,
  input  logic             pop,
  output fifo_entry_t      head,
  output logic [CNT_W-1:0] count
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/aac_row_sequencer.sv
// Frames product beats into rows, drives the split-carry accumulator and
// queues each completed row sum with its row index for downstream.
module aac_row_sequencer
  import aac_row_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = AAC_DATA_W,
  parameter int unsigned ROW_W    = AAC_ROW_W,
  parameter int unsigned MAX_COLS = 128,
  parameter int unsigned DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_last,
  output logic              acc_aac,
  output logic [DATA_W-1:0] acc_a,
  input  logic [DATA_W-1:0] acc_out,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [ROW_W-1:0]  r_row,
  output logic              err
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned CRED_W = CNT_W + 1;
  localparam int unsigned COL_W  = $clog2(MAX_COLS + 1);

  row_state_t        state;
  logic              accept;
  logic              pop;
  logic              pend1;
  logic              pend2;
  logic [ROW_W-1:0]  row_idx;
  logic [ROW_W-1:0]  row1;
  logic [ROW_W-1:0]  row2;
  logic [COL_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CRED_W-1:0] credit_next;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  assign accept  = p_valid && p_ready;
  assign pop     = r_valid && r_ready;
  assign r_valid = (fifo_count != '0);
  assign r_data  = head.data;
  assign r_row   = head.row;

  // Credits held next cycle: FIFO occupancy plus rows still in the capture pipe.
  always_comb begin
    credit_next = CRED_W'(fifo_count) + CRED_W'(pend2) - CRED_W'(pop)
                + CRED_W'(accept && p_last) + CRED_W'(pend1);
  end

  always_comb begin
    push_entry      = '0;
    push_entry.row  = row2;
    push_entry.data = acc_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ROW_IDLE;
      acc_a   <= '0;
      acc_aac <= 1'b0;
      pend1   <= 1'b0;
      pend2   <= 1'b0;
      row1    <= '0;
      row2    <= '0;
      row_idx <= '0;
      col_cnt <= '0;
      err     <= 1'b0;
      p_ready <= 1'b1;
    end else begin
      // An open row keeps accumulating; an idle sequencer restarts the sum.
      acc_a   <= accept ? p_data : '0;
      acc_aac <= (state == ROW_OPEN);
      pend1   <= accept && p_last;
      pend2   <= pend1;
      row1    <= row_idx;
      row2    <= row1;
      p_ready <= (credit_next < CRED_W'(DEPTH));
      if (accept) begin
        if (col_cnt == COL_W'(MAX_COLS)) err <= 1'b1;
        if (p_last) begin
          state   <= ROW_IDLE;
          row_idx <= row_idx + ROW_W'(1);
          col_cnt <= '0;
        end else begin
          state <= ROW_OPEN;
          if (col_cnt != COL_W'(MAX_COLS)) col_cnt <= col_cnt + COL_W'(1);
        end
      end
    end
  end

  aac_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (pend2),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
  );

endmodule
